// File: rtl/simon_pkg.sv
// Shared types, constants and symbol helpers for the Simon memory-game sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShowGap,
    StShowOn,
    StWaitInput,
    StWin,
    StLose
  } state_e;

  typedef logic [1:0] symbol_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr bits [15:0].
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [3:0] sym_to_onehot(symbol_t s);
    return 4'b0001 << s;
  endfunction

  function automatic logic is_onehot(logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic symbol_t onehot_to_sym(logic [3:0] v);
    symbol_t s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) s = symbol_t'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; the low two bits serve as the next game symbol.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic    clk,
  input  logic    rst_n,
  output symbol_t sym_o
);

  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
  assign sym_o  = lfsr_q[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= Seed;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/simon_sequencer.sv
// Simon game engine: plays a growing random symbol sequence on the LEDs and checks button answers.
// Define SIMON_TIMEOUT_EN to make an unanswered WAIT_INPUT fall into LOSE after TIMEOUT_CYCLES.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned SHOW_CYCLES    = 12_500_000,
  parameter int unsigned GAP_CYCLES     = 6_250_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_i,
  input  logic [3:0]                       botao_i,
  output logic [3:0]                       led_o,
  output logic                             busy_o,
  output logic                             win_o,
  output logic                             lose_o,
  output logic [$clog2(MAX_LEN + 1)-1:0]   level_o
);

  localparam int unsigned LvlW   = $clog2(MAX_LEN + 1);
  localparam int unsigned AddrW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned MaxSg  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCyc = (TIMEOUT_CYCLES > MaxSg) ? TIMEOUT_CYCLES : MaxSg;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] ShowLoad = CntW'(SHOW_CYCLES - 1);
  localparam logic [CntW-1:0] TmoLoad  = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [LvlW-1:0] idx_q, level_q, idx_next;
  logic [3:0]      led_q;
  symbol_t         mem_q [MAX_LEN];
  logic [3:0]      sync1_q, sync_q, prev_q;
  symbol_t         lfsr_sym, cur_sym;
  logic            press;

  simon_lfsr #(
    .Seed (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .sym_o (lfsr_sym)
  );

  assign idx_next = idx_q + LvlW'(1);
  assign cur_sym  = mem_q[idx_q[AddrW-1:0]];
  assign press    = (prev_q == 4'b0000) && (sync_q != 4'b0000);

  // Edge detector keeps tracking in every state so held buttons never count as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= botao_i;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      level_q <= '0;
      led_q   <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
    end else if (start_i) begin
      state_q  <= StShowGap;
      cnt_q    <= GapLoad;
      idx_q    <= '0;
      level_q  <= LvlW'(1);
      led_q    <= '0;
      mem_q[0] <= lfsr_sym;
    end else begin
      unique case (state_q)
        StIdle: led_q <= '0;
        StShowGap: begin
          if (cnt_q == '0) begin
            state_q <= StShowOn;
            cnt_q   <= ShowLoad;
            led_q   <= sym_to_onehot(cur_sym);
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StShowOn: begin
          if (cnt_q == '0) begin
            led_q <= '0;
            if (idx_next == level_q) begin
              state_q <= StWaitInput;
              idx_q   <= '0;
              cnt_q   <= TmoLoad;
            end else begin
              state_q <= StShowGap;
              idx_q   <= idx_next;
              cnt_q   <= GapLoad;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StWaitInput: begin
          led_q <= sync_q;
          if (press) begin
            cnt_q <= TmoLoad;
            if (!is_onehot(sync_q) || (onehot_to_sym(sync_q) != cur_sym)) begin
              state_q <= StLose;
              cnt_q   <= ShowLoad;
              led_q   <= 4'b1111;
            end else if (idx_next == level_q) begin
              idx_q <= '0;
              if (level_q == LvlW'(MAX_LEN)) begin
                state_q <= StWin;
                led_q   <= 4'b1111;
              end else begin
                mem_q[level_q[AddrW-1:0]] <= lfsr_sym;
                level_q <= level_q + LvlW'(1);
                state_q <= StShowGap;
                cnt_q   <= GapLoad;
                led_q   <= '0;
              end
            end else begin
              idx_q <= idx_next;
            end
          end
`ifdef SIMON_TIMEOUT_EN
          else if (cnt_q == '0) begin
            state_q <= StLose;
            cnt_q   <= ShowLoad;
            led_q   <= 4'b1111;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
`endif
        end
        StWin: led_q <= 4'b1111;
        StLose: begin
          if (cnt_q == '0) begin
            led_q <= ~led_q;
            cnt_q <= ShowLoad;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign led_o   = led_q;
  assign level_o = level_q;
  assign busy_o  = (state_q == StShowGap) || (state_q == StShowOn) || (state_q == StWaitInput);
  assign win_o   = (state_q == StWin);
  assign lose_o  = (state_q == StLose);

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer: table vectors, hand sequences and random games vs a model.
module tb_simon_sequencer;

  localparam int unsigned MaxLen = 3;
  localparam int unsigned Show   = 4;
  localparam int unsigned Gap    = 2;
  localparam int unsigned Tmo    = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i = 1'b0;
  logic [3:0] botao_i = 4'b0000;
  logic [3:0] led_o;
  logic       busy_o, win_o, lose_o;
  logic [1:0] level_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  m_sym_last;
  logic [1:0]  seq[$];

  simon_sequencer #(
    .MAX_LEN        (MaxLen),
    .SHOW_CYCLES    (Show),
    .GAP_CYCLES     (Gap),
    .TIMEOUT_CYCLES (Tmo),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .botao_i (botao_i),
    .led_o   (led_o),
    .busy_o  (busy_o),
    .win_o   (win_o),
    .lose_o  (lose_o),
    .level_o (level_o)
  );

  always #5 clk = ~clk;

  // Reference random source: 16-bit Fibonacci LFSR, taps 16,14,13,11, one step per clock.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr     <= 16'hACE1;
      m_sym_last <= 2'd0;
    end else begin
      m_sym_last <= m_lfsr[1:0];
      m_lfsr     <= lfsr_next(m_lfsr);
    end
  end

  function automatic logic [3:0] oh(input logic [1:0] s);
    logic [3:0] r;
    r = 4'b0000;
    r[s] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_game();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    seq.delete();
    seq.push_back(m_sym_last);
    chk("start_level", 32'(level_o), 1);
    chk("start_busy", 32'(busy_o), 1);
    chk("start_flags", {30'd0, win_o, lose_o}, 0);
  endtask

  // Entered at the first negedge of playback; leaves at the first negedge of WAIT_INPUT.
  task automatic playback();
    for (int i = 0; i < seq.size(); i++) begin
      for (int g = 0; g < Gap; g++) begin
        chk("gap_led", 32'(led_o), 0);
        tick();
      end
      for (int s = 0; s < Show; s++) begin
        chk("show_led", 32'(led_o), 32'(oh(seq[i])));
        tick();
      end
    end
    chk("wait_busy", 32'(busy_o), 1);
    chk("wait_level", 32'(level_o), 32'(seq.size()));
    chk("wait_led", 32'(led_o), 0);
  endtask

  // Returns one negedge after the FSM has acted on the synchronised edge.
  task automatic press(input logic [3:0] pat, output logic pre_lose);
    botao_i = pat;
    tick(2);
    pre_lose = lose_o;
    tick();
  endtask

  // outcome: 0 = next round started, 1 = lost, 2 = won.
  task automatic play_round(input int wrong_at, input logic [3:0] wrong_pat, output int outcome);
    logic       pl;
    logic [3:0] pat;
    outcome = 0;
    playback();
    for (int i = 0; i < seq.size(); i++) begin
      pat = (i == wrong_at) ? wrong_pat : oh(seq[i]);
      tick($urandom_range(0, 4));
      press(pat, pl);
      botao_i = 4'b0000;
      if (i == wrong_at) begin
        chk("lose_delay", 32'(pl), 0);
        chk("lose", 32'(lose_o), 1);
        chk("lose_busy", 32'(busy_o), 0);
        outcome = 1;
        return;
      end
      if (i == seq.size() - 1) begin
        if (seq.size() == MaxLen) begin
          chk("win", 32'(win_o), 1);
          chk("win_led", 32'(led_o), 32'hF);
          chk("win_busy", 32'(busy_o), 0);
          outcome = 2;
        end else begin
          seq.push_back(m_sym_last);
          chk("next_level", 32'(level_o), 32'(seq.size()));
          chk("next_led", 32'(led_o), 0);
        end
        return;
      end
      chk("echo_led", 32'(led_o), 32'(pat));
      chk("mid_lose", 32'(lose_o), 0);
      tick(2);
    end
  endtask

  task automatic check_blink();
    for (int k = 0; k < 4 * Show; k++) begin
      chk("blink", 32'(led_o), ((k / Show) % 2 == 0) ? 32'hF : 32'h0);
      tick();
    end
  endtask

  function automatic logic [3:0] rand_wrong(input logic [1:0] good);
    logic [3:0] p;
    p = 4'(($urandom_range(1, 15)));
    if (p == oh(good)) p = ~p;
    return p;
  endfunction

  typedef struct {
    int         kind;      // 0 correct, 1 wrong symbol offset pat[1:0], 2 literal pat
    logic [3:0] pat;
    logic       exp_lose;
    int         exp_level;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[7];
    logic       pl;
    logic [3:0] pat;
    logic [1:0] wsym;
    int         outcome;
    int         wa;

    vecs[0] = '{0, 4'b0000, 1'b0, 2};
    vecs[1] = '{1, 4'b0001, 1'b1, 1};
    vecs[2] = '{1, 4'b0010, 1'b1, 1};
    vecs[3] = '{1, 4'b0011, 1'b1, 1};
    vecs[4] = '{2, 4'b0101, 1'b1, 1};
    vecs[5] = '{2, 4'b1111, 1'b1, 1};
    vecs[6] = '{2, 4'b1100, 1'b1, 1};

    rst_n = 1'b0;
    tick(2);
    chk("rst_led", 32'(led_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_level", 32'(level_o), 0);
    chk("rst_flags", {30'd0, win_o, lose_o}, 0);
    rst_n = 1'b1;
    tick(3);

    // Table vectors: single answer in round one.
    foreach (vecs[v]) begin
      tick($urandom_range(0, 3));
      start_game();
      playback();
      case (vecs[v].kind)
        0:       pat = oh(seq[0]);
        1: begin
          wsym = seq[0] + vecs[v].pat[1:0];
          pat  = oh(wsym);
        end
        default: pat = vecs[v].pat;
      endcase
      tick(1);
      press(pat, pl);
      botao_i = 4'b0000;
      chk("vec_lose", 32'(lose_o), 32'(vecs[v].exp_lose));
      chk("vec_level", 32'(level_o), 32'(vecs[v].exp_level));
      chk("vec_busy", 32'(busy_o), 32'(!vecs[v].exp_lose));
    end

    // Full game to WIN, then restart from WIN.
    start_game();
    outcome = 0;
    while (outcome == 0) play_round(-1, 4'b0000, outcome);
    chk("full_game_won", 32'(outcome), 2);
    tick(5);
    chk("win_hold", 32'(win_o), 1);
    start_game();
    playback();

    // Wrong answer in round two, blink, then restart from LOSE.
    start_game();
    play_round(-1, 4'b0000, outcome);
    wsym = seq[1] + 2'd1;
    play_round(1, oh(wsym), outcome);
    check_blink();
    start_game();
    playback();

    // No answer at all.
`ifdef SIMON_TIMEOUT_EN
    tick(Tmo - 1);
    chk("tmo_early", 32'(lose_o), 0);
    tick();
    chk("tmo_lose", 32'(lose_o), 1);
`else
    tick(1000);
    chk("no_tmo_busy", 32'(busy_o), 1);
    chk("no_tmo_lose", 32'(lose_o), 0);
`endif

    // Restart in the middle of SHOW_ON.
    start_game();
    tick(Gap + 1);
    chk("mid_show_led", 32'(led_o), 32'(oh(seq[0])));
    start_game();
    playback();

    // Asynchronous reset during SHOW_ON.
    start_game();
    tick(Gap + 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led_o), 0);
    chk("async_rst_busy", 32'(busy_o), 0);
    chk("async_rst_level", 32'(level_o), 0);
    tick();
    rst_n = 1'b1;
    tick(2);

    // Random games.
    for (int g = 0; g < 8; g++) begin
      tick($urandom_range(0, 7));
      start_game();
      outcome = 0;
      while (outcome == 0) begin
        wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, seq.size() - 1)) : -1;
        pat = (wa >= 0) ? rand_wrong(seq[wa]) : 4'b0000;
        play_round(wa, pat, outcome);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
